mcu_spi_hub: RTL and testbench
==============================

Name: mcu_spi_hub

Overview:
Parametrised successor of the MCU SPI byte interface. It is a fully synchronous SPI slave: SCK, SS and MOSI are oversampled in the core clock domain, so the block has no SPI-clock-domain logic. It decodes a leading target-ID byte and routes payload bytes to NUM_TARGETS core targets through per-target strobes. It returns the selected target's reply byte on MISO and reports transaction start, end and error events. It sits between the MCU SPI pins and the sys/hid/osd/sdc/etc. targets.

Parameters:
NUM_TARGETS, 4, number of targets; target IDs 0..NUM_TARGETS-1 (1..256).
CPOL, 1, SCK idle level; CPHA is fixed at 1: data is set up on the leading edge and sampled on the trailing edge.
CNT_W, 8, width of the payload byte counter (saturating).
SYNC_STAGES, 2, synchroniser depth on SCK/SS/MOSI (2..3).

Ports:
clk  in  1  core clock; must be >= 8x SCK frequency.
reset_n  in  1  asynchronous, active-low reset.
spi_io_ss  in  1  chip select, active low.
spi_io_clk  in  1  SPI clock.
spi_io_din  in  1  MOSI.
spi_io_dout  out  1  MISO, registered in clk.
mcu_strobe  out  NUM_TARGETS  one-hot, 1-cycle pulse per received payload byte.
mcu_start  out  1  pulses together with the first payload strobe of a transaction.
mcu_end  out  1  1-cycle pulse on SS deassert if a target byte was received.
mcu_err  out  1  1-cycle pulse when the target ID is >= NUM_TARGETS.
mcu_target  out  8  current target ID.
mcu_byte_cnt  out  CNT_W  index of the current payload byte (0 = first).
mcu_din  in  8*NUM_TARGETS  reply bytes; target t occupies [8t+7:8t].
mcu_dout  out  8  last received payload byte, valid while a strobe is high.

Behaviour:
- Reset (async assert, sync release): all outputs 0. The shift registers, bit counter and byte counter clear. The FSM enters WAIT_IDLE.
- Synchronisers: SYNC_STAGES flops on each input. Edge detect uses the last two synchronised SCK samples. The leading edge is the transition away from CPOL; the trailing edge is the transition back to CPOL.
- FSM states and transitions:
  - WAIT_IDLE: stays until synchronised SS is high, then goes to IDLE. A transaction already in progress when reset is released is therefore ignored.
  - IDLE: SS low goes to TARGET. Bit counter = 0, spi_io_dout = 0.
  - TARGET: shifts in 8 bits MSB-first, one per trailing edge. On the 8th bit it latches mcu_target.
    - If the ID is < NUM_TARGETS, go to PAYLOAD and set mcu_byte_cnt = 0.
    - Otherwise pulse mcu_err and go to IGNORE.
    - MISO returns 0x00 during the target byte.
  - PAYLOAD: on each 8th trailing edge, in the next cycle:
    - set mcu_dout to the byte;
    - pulse mcu_strobe[mcu_target] for one cycle;
    - pulse mcu_start with the first strobe only.
    - mcu_byte_cnt increments on the cycle after each strobe and saturates at 2^CNT_W-1. The strobe for a saturated byte still fires.
  - IGNORE: clocks bits but produces no strobes. MISO = 0.
  - Any state except WAIT_IDLE: synchronised SS high returns to IDLE. mcu_end pulses if the previous state was PAYLOAD or IGNORE. A partial byte is discarded with no strobe.
- MISO path:
  - The TX shift register loads mcu_din[8*mcu_target +: 8] in the cycle after each strobe. It also loads on the cycle after the target byte completes, which provides reply byte 0. Targets therefore have one clk cycle after a strobe to present the next reply.
  - On each leading edge, spi_io_dout <= tx_sr[7] and tx_sr shifts left.
  - Before the first leading edge of a byte, spi_io_dout holds its previous value.
- Simultaneous SS deassert and byte completion: SS wins. No strobe, no counter update.
- Only one strobe bit can be high in any cycle. mcu_target changes only at the end of the target byte.

Test Plan:
- SS low, send 0x02 then 0xA5, 0x3C with CPOL=1 and clk = 8x SCK -> mcu_target=2; mcu_strobe=0b0100 twice; mcu_dout=0xA5 then 0x3C; mcu_start with the first strobe only; mcu_byte_cnt 0 then 1; mcu_end one pulse after SS rises.
- Target 1 with mcu_din[15:8]=0x5A, then target 1 updates to 0xC3 one cycle after the first strobe, 3 payload bytes -> MISO bytes 0x00, 0x5A, 0xC3, 0xC3.
- Target 0x07 with NUM_TARGETS=4 -> mcu_err pulses once; no strobes; MISO all zero; mcu_end pulses on SS release.
- SS deasserted after 5 bits of the second payload byte -> exactly one strobe; next transaction restarts cleanly with mcu_byte_cnt=0.
- reset_n pulsed low mid-payload while SS stays low -> outputs 0; the remaining bytes produce no strobes; the next SS low/high-framed transaction works.
- CNT_W=2, 6 payload bytes -> mcu_byte_cnt 0,1,2,3,3,3; 6 strobes.

Source files
------------

// File: rtl/mcu_spi_hub.sv
// -----------------------------------------------------------------------------
// mcu_spi_hub
//
// Purpose:
//   SPI slave (CPHA = 1, configurable CPOL) that runs entirely in the core
//   clock domain. SCK, SS and MOSI are oversampled through synchronisers, so
//   there is no logic clocked by the SPI clock. The first byte of each
//   transaction selects a target. Every following payload byte is handed to
//   that target through a one-cycle strobe. The target's reply byte is shifted
//   back out on MISO.
//
// Ports:
//   clk           core clock, at least 8x the SCK frequency
//   reset_n       asynchronous active-low reset
//   spi_io_ss     chip select, active low
//   spi_io_clk    SPI clock
//   spi_io_din    MOSI
//   spi_io_dout   MISO, registered in clk
//   mcu_strobe    one-hot pulse per received payload byte
//   mcu_start     pulses with the first payload strobe of a transaction
//   mcu_end       pulses on SS release when a valid or invalid target was seen
//   mcu_err       pulses when the target ID is out of range
//   mcu_target    current target ID
//   mcu_byte_cnt  index of the current payload byte, saturating
//   mcu_din       reply bytes, target t at [8t+7:8t]
//   mcu_dout      last received payload byte
// -----------------------------------------------------------------------------
module mcu_spi_hub #(
  parameter int   NUM_TARGETS = 4,
  parameter logic CPOL        = 1'b1,
  parameter int   CNT_W       = 8,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     spi_io_ss,
  input  logic                     spi_io_clk,
  input  logic                     spi_io_din,
  output logic                     spi_io_dout,
  output logic [NUM_TARGETS-1:0]   mcu_strobe,
  output logic                     mcu_start,
  output logic                     mcu_end,
  output logic                     mcu_err,
  output logic [7:0]               mcu_target,
  output logic [CNT_W-1:0]         mcu_byte_cnt,
  input  logic [8*NUM_TARGETS-1:0] mcu_din,
  output logic [7:0]               mcu_dout
);

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_TARGET,
    ST_PAYLOAD,
    ST_IGNORE
  } state_t;

  localparam logic [8:0]             NUM_T9   = 9'(NUM_TARGETS);
  localparam logic [CNT_W-1:0]       CNT_MAX  = '1;
  localparam logic [NUM_TARGETS-1:0] ONE_HOT0 = NUM_TARGETS'(1);

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;
  logic                   ss_s;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   lead;
  logic                   trail;

  logic [2:0] bit_cnt;
  logic [7:0] rx_sr;
  logic [7:0] rx_byte;
  logic [7:0] tx_sr;
  logic       tgt_done;
  logic       load_tx;
  logic       first_pend;

  logic in_frame;
  logic shift_en;
  logic byte_done;
  logic id_ok;
  logic tgt_ok;
  logic tgt_bad;
  logic pay_done;
  logic end_evt;

  // Synchronisers. SS resets to "selected" so that WAIT_IDLE only leaves
  // after a genuine high level has been observed on the pin; SCK resets to
  // its idle level so that release of reset cannot fake an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_sync   <= '0;
      sck_sync  <= {SYNC_STAGES{CPOL}};
      mosi_sync <= '0;
      sck_prev  <= CPOL;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_io_ss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_io_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_io_din};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead  = (sck_prev == CPOL) && (sck_s != CPOL);
  assign trail = (sck_prev != CPOL) && (sck_s == CPOL);

  // A byte only completes while SS is still low; a simultaneous SS release
  // takes priority and the byte is dropped.
  assign in_frame  = (state == ST_TARGET) || (state == ST_PAYLOAD) ||
                     (state == ST_IGNORE);
  assign shift_en  = in_frame && trail && !ss_s;
  assign byte_done = shift_en && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr[6:0], mosi_s};
  assign id_ok     = {1'b0, rx_byte} < NUM_T9;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WAIT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the per-cycle events that drive the datapath.
  always_comb begin
    state_next = state;
    tgt_ok     = 1'b0;
    tgt_bad    = 1'b0;
    pay_done   = 1'b0;
    end_evt    = 1'b0;
    case (state)
      ST_WAIT_IDLE: begin
        if (ss_s) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!ss_s) state_next = ST_TARGET;
      end
      ST_TARGET: begin
        if (ss_s) begin
          state_next = ST_IDLE;
        end else if (byte_done) begin
          if (id_ok) begin
            tgt_ok     = 1'b1;
            state_next = ST_PAYLOAD;
          end else begin
            tgt_bad    = 1'b1;
            state_next = ST_IGNORE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (ss_s) begin
          state_next = ST_IDLE;
          end_evt    = 1'b1;
        end else if (byte_done) begin
          pay_done = 1'b1;
        end
      end
      ST_IGNORE: begin
        if (ss_s) begin
          state_next = ST_IDLE;
          end_evt    = 1'b1;
        end
      end
      default: state_next = ST_WAIT_IDLE;
    endcase
  end

  // Receive side: bit/byte assembly, target latch, strobes and byte count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt      <= '0;
      rx_sr        <= '0;
      mcu_target   <= '0;
      mcu_byte_cnt <= '0;
      mcu_dout     <= '0;
      mcu_strobe   <= '0;
      mcu_start    <= 1'b0;
      mcu_end      <= 1'b0;
      mcu_err      <= 1'b0;
      first_pend   <= 1'b0;
      tgt_done     <= 1'b0;
      load_tx      <= 1'b0;
    end else begin
      mcu_strobe <= '0;
      mcu_start  <= 1'b0;
      mcu_end    <= end_evt;
      mcu_err    <= tgt_bad;
      tgt_done   <= tgt_ok;
      // One cycle of slack after a strobe (or the target byte) so the
      // target can present its next reply before it is sampled.
      load_tx    <= tgt_done || (|mcu_strobe);

      if (!in_frame) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= rx_byte;
      end

      if (tgt_ok || tgt_bad) begin
        mcu_target <= rx_byte;
      end

      if (tgt_ok) begin
        mcu_byte_cnt <= '0;
      end else if ((|mcu_strobe) && (mcu_byte_cnt != CNT_MAX)) begin
        mcu_byte_cnt <= mcu_byte_cnt + 1'b1;
      end

      if (tgt_ok) begin
        first_pend <= 1'b1;
      end else if (pay_done || (state == ST_IDLE)) begin
        first_pend <= 1'b0;
      end

      if (pay_done) begin
        mcu_dout   <= rx_byte;
        mcu_strobe <= ONE_HOT0 << mcu_target;
        mcu_start  <= first_pend;
      end
    end
  end

  // Transmit side. The reply register is loaded well before the next
  // leading edge because SCK is at least 8x slower than clk, so load and
  // shift never need to happen in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sr       <= '0;
      spi_io_dout <= 1'b0;
    end else if (!in_frame || (state == ST_IGNORE)) begin
      tx_sr       <= '0;
      spi_io_dout <= 1'b0;
    end else if (load_tx) begin
      tx_sr <= mcu_din[{mcu_target, 3'b000} +: 8];
    end else if (lead) begin
      spi_io_dout <= tx_sr[7];
      tx_sr       <= {tx_sr[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_mcu_spi_hub.sv
// -----------------------------------------------------------------------------
// tb_mcu_spi_hub
//
// Purpose:
//   Self-checking bench for mcu_spi_hub (NUM_TARGETS = 4, CPOL = 1,
//   CNT_W = 2). Acts as an SPI master with SCK = clk / 8. A transaction-level
//   model predicts the strobe stream, error/end pulses and MISO bytes; a
//   monitor compares every strobe cycle against it, and literal checks pin
//   the expected values of the directed vectors.
// -----------------------------------------------------------------------------
module tb_mcu_spi_hub;

  localparam int NT    = 4;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [NT-1:0]    strobe;
    logic [7:0]       data;
    logic             start;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic              ss;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic [NT-1:0]     mcu_strobe;
  logic              mcu_start;
  logic              mcu_end;
  logic              mcu_err;
  logic [7:0]        mcu_target;
  logic [CNT_W-1:0]  mcu_byte_cnt;
  logic [8*NT-1:0]   mcu_din;
  logic [7:0]        mcu_dout;

  int n_tests;
  int n_fail;
  int err_seen;
  int end_seen;
  int exp_err;
  int exp_end;

  exp_t       exp_q[$];
  logic [7:0] exp_miso[$];
  logic [7:0] got_miso[$];
  logic [7:0] log_dout[$];
  logic [CNT_W-1:0] log_cnt[$];
  logic [7:0] reply_tbl[NT];
  logic [7:0] pay[16];

  logic       upd_arm;
  logic [7:0] upd_val;
  logic [7:0] upd_tgt;

  mcu_spi_hub #(
    .NUM_TARGETS(NT),
    .CPOL(1'b1),
    .CNT_W(CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .spi_io_ss(ss),
    .spi_io_clk(sck),
    .spi_io_din(mosi),
    .spi_io_dout(miso),
    .mcu_strobe(mcu_strobe),
    .mcu_start(mcu_start),
    .mcu_end(mcu_end),
    .mcu_err(mcu_err),
    .mcu_target(mcu_target),
    .mcu_byte_cnt(mcu_byte_cnt),
    .mcu_din(mcu_din),
    .mcu_dout(mcu_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every strobe must match the next predicted payload
  // event, and mcu_start may never appear without a strobe.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (mcu_err) err_seen++;
      if (mcu_end) end_seen++;
      if (mcu_strobe != '0) begin
        log_dout.push_back(mcu_dout);
        log_cnt.push_back(mcu_byte_cnt);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(mcu_strobe), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("strobe", 32'(mcu_strobe), 32'(e.strobe));
          check("dout", 32'(mcu_dout), 32'(e.data));
          check("start", 32'(mcu_start), 32'(e.start));
          check("byte_cnt", 32'(mcu_byte_cnt), 32'(e.cnt));
        end
      end else if (mcu_start) begin
        check("start_without_strobe", 32'(mcu_start), 32'h0);
      end
    end
  end

  // Emulates a target that changes its reply one cycle after it is strobed.
  always @(negedge clk) begin
    if (upd_arm && (mcu_strobe != '0)) begin
      upd_arm = 1'b0;
      @(posedge clk);
      #1;
      mcu_din[8*upd_tgt +: 8] = upd_val;
    end
  end

  function automatic logic [7:0] miso_model(input logic [7:0] id, input int j,
                                            input bit upd, input logic [7:0] nv,
                                            input logic [7:0] first);
    if ((id >= 8'(NT)) || (j == 0)) return 8'h00;
    if (j == 1) return first;
    return upd ? nv : first;
  endfunction

  task automatic drive_din();
    for (int t = 0; t < NT; t++) mcu_din[8*t +: 8] = reply_tbl[t];
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = b[7-i];
      wait_clks(4);
      got[7-i] = miso;
      sck = 1'b1;
      wait_clks(4);
    end
  endtask

  task automatic clear_obs();
    err_seen = 0;
    end_seen = 0;
    got_miso.delete();
    log_dout.delete();
    log_cnt.delete();
  endtask

  // One framed transaction: target byte, then n_bytes payload bytes taken
  // from pay[], the last of which carries only last_bits bits.
  task automatic applyStimulus(input logic [7:0] id, input int n_bytes, input int last_bits,
                               input bit upd, input logic [7:0] nv);
    logic [7:0] got;
    logic [7:0] first;
    int n_full;
    int nb;
    exp_t e;
    n_full = (last_bits < 8) ? n_bytes - 1 : n_bytes;
    first  = (id < 8'(NT)) ? reply_tbl[id] : 8'h00;
    exp_err = (id >= 8'(NT)) ? 1 : 0;
    exp_end = 1;
    exp_miso.delete();
    for (int j = 0; j <= n_full; j++) exp_miso.push_back(miso_model(id, j, upd, nv, first));
    if (id < 8'(NT)) begin
      for (int k = 0; k < n_full; k++) begin
        e.strobe = NT'(1) << id;
        e.data   = pay[k];
        e.start  = (k == 0);
        e.cnt    = (k > (1 << CNT_W) - 1) ? CNT_W'((1 << CNT_W) - 1) : CNT_W'(k);
        exp_q.push_back(e);
      end
    end
    clear_obs();
    upd_arm = upd;
    upd_val = nv;
    upd_tgt = id;
    ss = 1'b0;
    wait_clks(4);
    send_byte(id, 8, got);
    got_miso.push_back(got);
    for (int k = 0; k < n_bytes; k++) begin
      nb = (k == n_bytes - 1) ? last_bits : 8;
      send_byte(pay[k], nb, got);
      if (nb == 8) got_miso.push_back(got);
    end
    wait_clks(4);
    ss = 1'b1;
    wait_clks(10);
    upd_arm = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_err_count"}, 32'(err_seen), 32'(exp_err));
    check({tag, "_end_count"}, 32'(end_seen), 32'(exp_end));
    check({tag, "_missing_strobes"}, 32'(exp_q.size()), 32'h0);
    check({tag, "_miso_count"}, 32'(got_miso.size()), 32'(exp_miso.size()));
    for (int j = 0; j < exp_miso.size() && j < got_miso.size(); j++)
      check({tag, "_miso_byte"}, 32'(got_miso[j]), 32'(exp_miso[j]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobe"}, 32'(mcu_strobe), 32'h0);
    check({tag, "_start"}, 32'(mcu_start), 32'h0);
    check({tag, "_end"}, 32'(mcu_end), 32'h0);
    check({tag, "_err"}, 32'(mcu_err), 32'h0);
    check({tag, "_target"}, 32'(mcu_target), 32'h0);
    check({tag, "_byte_cnt"}, 32'(mcu_byte_cnt), 32'h0);
    check({tag, "_dout"}, 32'(mcu_dout), 32'h0);
    check({tag, "_miso"}, 32'(miso), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] got;
    exp_t e;
    n_tests = 0;
    n_fail  = 0;
    upd_arm = 1'b0;
    upd_val = '0;
    upd_tgt = '0;
    reply_tbl[0] = 8'h4B;
    reply_tbl[1] = 8'h5A;
    reply_tbl[2] = 8'h6D;
    reply_tbl[3] = 8'h7E;
    drive_din();
    clear_obs();
    reset_n = 1'b0;
    ss      = 1'b1;
    sck     = 1'b1;
    mosi    = 1'b0;
    wait_clks(5);
    check_all_zero("reset");
    reset_n = 1'b1;
    wait_clks(10);

    $display("[TB] basic transfer to target 2");
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    applyStimulus(8'h02, 2, 8, 1'b0, 8'h00);
    checkOutput("t1");
    check("t1_target", 32'(mcu_target), 32'h2);
    check("t1_strobes", 32'(log_dout.size()), 32'd2);
    if (log_dout.size() == 2) begin
      check("t1_dout0", 32'(log_dout[0]), 32'hA5);
      check("t1_dout1", 32'(log_dout[1]), 32'h3C);
      check("t1_cnt1", 32'(log_cnt[1]), 32'h1);
    end

    $display("[TB] reply update on target 1");
    pay[0] = 8'h01;
    pay[1] = 8'h02;
    pay[2] = 8'h03;
    applyStimulus(8'h01, 3, 8, 1'b1, 8'hC3);
    checkOutput("t2");
    check("t2_miso_len", 32'(got_miso.size()), 32'd4);
    if (got_miso.size() == 4) begin
      check("t2_miso0", 32'(got_miso[0]), 32'h00);
      check("t2_miso1", 32'(got_miso[1]), 32'h5A);
      check("t2_miso2", 32'(got_miso[2]), 32'hC3);
      check("t2_miso3", 32'(got_miso[3]), 32'hC3);
    end
    drive_din();

    $display("[TB] out-of-range target 7");
    pay[0] = 8'h12;
    pay[1] = 8'h34;
    applyStimulus(8'h07, 2, 8, 1'b0, 8'h00);
    checkOutput("t3");
    check("t3_target", 32'(mcu_target), 32'h7);
    check("t3_err_lit", 32'(err_seen), 32'd1);
    check("t3_strobes", 32'(log_dout.size()), 32'd0);

    $display("[TB] truncated second payload byte");
    pay[0] = 8'h11;
    pay[1] = 8'h22;
    applyStimulus(8'h03, 2, 5, 1'b0, 8'h00);
    checkOutput("t4");
    check("t4_strobes", 32'(log_dout.size()), 32'd1);
    pay[0] = 8'h99;
    applyStimulus(8'h00, 1, 8, 1'b0, 8'h00);
    checkOutput("t4b");
    check("t4b_strobes", 32'(log_cnt.size()), 32'd1);
    if (log_cnt.size() == 1) check("t4b_cnt0", 32'(log_cnt[0]), 32'h0);

    $display("[TB] reset mid-payload");
    clear_obs();
    e.strobe = NT'(1) << 1;
    e.data   = 8'h81;
    e.start  = 1'b1;
    e.cnt    = '0;
    exp_q.push_back(e);
    ss = 1'b0;
    wait_clks(4);
    send_byte(8'h01, 8, got);
    send_byte(8'h81, 8, got);
    send_byte(8'h42, 3, got);
    reset_n = 1'b0;
    wait_clks(3);
    check_all_zero("midreset");
    reset_n = 1'b1;
    wait_clks(2);
    send_byte(8'h55, 8, got);
    send_byte(8'h66, 8, got);
    wait_clks(4);
    ss = 1'b1;
    wait_clks(10);
    check("t5_strobes", 32'(log_dout.size()), 32'd1);
    check("t5_missing", 32'(exp_q.size()), 32'h0);
    check("t5_end", 32'(end_seen), 32'd0);
    check("t5_err", 32'(err_seen), 32'd0);
    pay[0] = 8'h77;
    applyStimulus(8'h02, 1, 8, 1'b0, 8'h00);
    checkOutput("t5b");

    $display("[TB] byte counter saturation");
    for (int k = 0; k < 6; k++) pay[k] = 8'(8'h10 + k);
    applyStimulus(8'h02, 6, 8, 1'b0, 8'h00);
    checkOutput("t6");
    check("t6_strobes", 32'(log_cnt.size()), 32'd6);
    if (log_cnt.size() == 6) begin
      check("t6_cnt0", 32'(log_cnt[0]), 32'h0);
      check("t6_cnt1", 32'(log_cnt[1]), 32'h1);
      check("t6_cnt2", 32'(log_cnt[2]), 32'h2);
      check("t6_cnt3", 32'(log_cnt[3]), 32'h3);
      check("t6_cnt4", 32'(log_cnt[4]), 32'h3);
      check("t6_cnt5", 32'(log_cnt[5]), 32'h3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
